// File: rtl/riscv_pkg.sv
// Shared definitions for the aricriscv front end.
//   XLEN / ILEN   : address and instruction widths
//   RESET_PC      : default PC loaded at reset
//   NOP           : canonical no-op encoding (addi x0, x0, 0)
//   fetch_entry_t : one buffered fetch result, {pc, instr}
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of every handshake signal around the fetch stage.
//   imem_req_*  : request channel to instruction memory
//   imem_resp_* : in-order response channel, no backpressure
//   redirect_*  : flush/restart command from execute
//   out_*       : valid/ready channel towards decode
// master : the fetch stage itself
// slave  : its environment (memory, execute, decode)
interface fetch_stage_if #(
  parameter int XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_pc, out_instr,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_pc, out_instr,
    output out_ready
  );

endinterface

// File: rtl/fetch_stage_fifo.sv
// DEPTH-entry synchronous instruction buffer with flush.
//   clk, rst_n    : clock and asynchronous active-low reset
//   flush_i       : empties the buffer; overrides push and pop this cycle
//   push_i        : write push_data_i at the tail
//   push_data_i   : entry to store
//   pop_i         : drop the head entry (ignored when empty)
//   count_o       : number of valid entries (registered)
//   empty_o       : no valid entries
//   head_o        : head entry, read combinationally from storage
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output fetch_entry_t  head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A full buffer can still take a write when its head leaves in the same cycle.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared at reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // The fetch credit scheme must make a write into a full buffer impossible.
  overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : fetch_stage_if master port
//                - imem request issue under a credit of DEPTH
//                - imem responses tagged with their PC and buffered
//                - (pc, instr) presented to decode via valid/ready
//                - redirect flushes the buffer and drops in-flight responses
module fetch_stage #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDIT = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;
  logic [CW:0]     in_use;
  logic [XLEN-1:0] redirect_tgt;
  logic            req_valid;
  logic            accept;
  logic            resp_keep;
  logic            resp_drop;
  logic            pop;

  assign redirect_tgt = {bus.redirect_pc[XLEN-1:2], 2'b00};

  // Credit counts both in-flight requests and buffered entries so that every
  // response is guaranteed a slot. Gating with rst_n keeps the request line
  // low for the whole reset interval, not only after the first edge.
  assign in_use    = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign req_valid = rst_n && !bus.redirect_valid && (in_use < CREDIT);
  assign accept    = req_valid && bus.imem_req_ready;

  assign resp_keep = bus.imem_resp_valid && (drop_cnt_q == '0) && !bus.redirect_valid;
  assign resp_drop = bus.imem_resp_valid && (drop_cnt_q != '0);
  assign pop       = !fifo_empty && bus.out_ready && !bus.redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle is stale; the response
      // arriving right now is discarded as well, so it is not counted.
      fetch_pc_d    = redirect_tgt;
      resp_pc_d     = redirect_tgt;
      outstanding_d = outstanding_q - CW'(bus.imem_resp_valid);
      drop_cnt_d    = outstanding_q - CW'(bus.imem_resp_valid);
    end else begin
      if (accept)    fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_keep) resp_pc_d  = resp_pc_q + XLEN'(4);
      outstanding_d = outstanding_q + CW'(accept) - CW'(bus.imem_resp_valid);
      if (resp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign push_entry = '{pc: resp_pc_q, instr: bus.imem_resp_data};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (bus.redirect_valid),
    .push_i      (resp_keep),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.out_valid      = !fifo_empty;
  assign bus.out_pc         = fifo_head.pc;
  assign bus.out_instr      = fifo_head.instr;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    int          t;
    logic [31:0] d;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(32)) bus ();

  fetch_stage #(
    .XLEN     (32),
    .RESET_PC (RST_PC),
    .DEPTH    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb[$];
  rsp_t        mq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_t  = -1;
  int          lat_min = 1;
  int          lat_max = 1;
  int          n_acc   = 0;
  int          n_out   = 0;
  int          first_acc = -1;
  int          first_ov  = -1;
  logic [31:0] exp_pc  = RST_PC;
  logic [31:0] want_pc = RST_PC;
  bit          want_first = 1'b0;
  logic        last_rv, last_ov, last_resp;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Entered just after a rising edge; drives memory responses, samples the
  // DUT mid-cycle, updates the models, then advances one clock.
  task automatic step();
    exp_t e;
    rsp_t r;
    int   t;
    if (mq.size() > 0 && mq[0].t == cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mq[0].d;
      void'(mq.pop_front());
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
    end
    #1;
    last_rv   = bus.imem_req_valid;
    last_ov   = bus.out_valid;
    last_resp = bus.imem_resp_valid;
    if (bus.out_valid && first_ov < 0) first_ov = cyc;
    if (bus.redirect_valid) begin
      check("no_req_in_redirect", bus.imem_req_valid, 1'b0);
      sb.delete();
      exp_pc = {bus.redirect_pc[31:2], 2'b00};
      want_first = 1'b1;
      want_pc    = exp_pc;
    end else if (bus.out_valid && bus.out_ready) begin
      check("sb_avail", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_pc", bus.out_pc, e.pc);
        check("out_instr", bus.out_instr, e.instr);
        if (want_first) begin
          check("first_pc", bus.out_pc, want_pc);
          want_first = 1'b0;
        end
      end
      n_out++;
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      if (first_acc < 0) first_acc = cyc;
      check("req_addr", bus.imem_req_addr, exp_pc);
      sb.push_back('{pc: exp_pc, instr: memf(exp_pc)});
      exp_pc = exp_pc + 32'd4;
      t = cyc + int'($urandom_range(lat_max, lat_min));
      if (t <= last_t) t = last_t + 1;
      last_t = t;
      r.t = t;
      r.d = memf(bus.imem_req_addr);
      mq.push_back(r);
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    bus.imem_req_ready = 1'b0;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    repeat (10) step();
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.out_ready       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_pc", bus.out_pc, 32'h0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check("rst_req_addr", bus.imem_req_addr, RST_PC);

    // Basic streaming, latency 1.
    rst_n = 1'b1;
    want_first = 1'b1;
    want_pc    = RST_PC;
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b1;
    repeat (12) step();
    check("first_out_latency", first_ov - first_acc, 2);
    drain();

    // Decode stalls: only DEPTH requests go out, then fetch resumes.
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b0;
    base = n_acc;
    repeat (10) step();
    check("stall_acc_count", n_acc - base, 2);
    check("stall_req_valid", last_rv, 1'b0);
    check("stall_out_valid", last_ov, 1'b1);
    bus.out_ready = 1'b1;
    repeat (12) step();
    drain();

    // Redirect with two requests outstanding.
    lat_min = 3; lat_max = 3;
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b1;
    base = n_acc;
    repeat (2) step();
    check("redir_outstanding", n_acc - base, 2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    step();
    bus.redirect_valid = 1'b0;
    lat_min = 1; lat_max = 1;
    step();
    check("redir_flush_ov", last_ov, 1'b0);
    repeat (12) step();
    check("redir_first_seen", want_first, 1'b0);
    drain();

    // Redirect coinciding with a response and a pop.
    lat_min = 2; lat_max = 2;
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b0;
    repeat (3) step();
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0202;
    step();
    check("combo_setup", {last_resp, last_ov}, 2'b11);
    bus.redirect_valid = 1'b0;
    lat_min = 1; lat_max = 1;
    step();
    check("combo_flush_ov", last_ov, 1'b0);
    repeat (12) step();
    check("combo_first_seen", want_first, 1'b0);
    drain();

    // Random backpressure and latency, 1000 instructions.
    lat_min = 1; lat_max = 3;
    base = n_out;
    for (int i = 0; i < 20000 && (n_out - base) < 1000; i++) begin
      bus.imem_req_ready = 1'($urandom_range(0, 1));
      bus.out_ready      = ($urandom_range(0, 3) != 0);
      step();
    end
    check("rand_1000_done", (n_out - base) >= 1000, 1'b1);
    drain();

    // Asynchronous reset with a full buffer.
    lat_min = 1; lat_max = 1;
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b0;
    repeat (6) step();
    check("pre_rst_full", last_ov, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", bus.out_valid, 1'b0);
    check("async_rst_req_valid", bus.imem_req_valid, 1'b0);
    check("async_rst_out_pc", bus.out_pc, 32'h0);
    sb.delete();
    mq.delete();
    last_t = -1;
    exp_pc = RST_PC;
    want_first = 1'b1;
    want_pc    = RST_PC;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (12) step();
    check("post_rst_first_seen", want_first, 1'b0);
    drain();
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch front end of the aricriscv pipeline. It owns the PC, issues in-order requests to instruction memory under a credit limit, and buffers returned instructions in a small FIFO. It presents (pc, instr) pairs to the decode stage through a valid/ready handshake. Branch and jump redirects from execute flush the stage and discard responses that are still in flight.

Parameters:
XLEN, 32, PC/address width
RESET_PC, 32'h0000_0000, PC value loaded at reset
DEPTH, 2, instruction buffer entries; also the cap on outstanding requests plus buffered entries

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  word-aligned fetch address
imem_resp_valid  input  1  response valid; in order, no backpressure, latency >= 1 cycle
imem_resp_data  input  32  instruction word
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  XLEN  new PC; bits [1:0] are ignored and treated as 0
out_valid  output  1  decode-side valid
out_ready  input  1  decode accepts
out_pc  output  XLEN  PC of the head instruction
out_instr  output  32  head instruction

Behaviour:
- Reset (asynchronous, rst_n=0):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC
  - FIFO empty, outstanding=0, drop_cnt=0
  - imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0
  - Reset mid-transaction abandons all in-flight requests; memory is reset by the same rst_n.
- Credit: imem_req_valid = !redirect_valid && (outstanding + fifo_count < DEPTH). Credit uses registered counts; a pop in a cycle frees credit starting the next cycle.
- Request: imem_req_addr=fetch_pc. On accept (valid && ready), fetch_pc += 4 and outstanding increments.
- Response when drop_cnt==0:
  - Push {resp_pc, imem_resp_data} into the FIFO, resp_pc += 4, outstanding decrements.
  - The credit rule guarantees the FIFO never overflows; an overflow is an assertion failure.
- Response when drop_cnt>0: discard it, decrement drop_cnt and outstanding.
- Simultaneous accept and response: outstanding stays unchanged.
- Output: out_valid = FIFO non-empty; out_pc/out_instr are the head entry (combinational from storage). Pop occurs on out_valid && out_ready. Push and pop may occur in the same cycle when not full. 0-cycle bypass from response to output is not allowed; minimum latency from response to out_valid is 1 cycle.
- Redirect (redirect_valid=1, highest priority):
  - fetch_pc and resp_pc load {redirect_pc[XLEN-1:2],2'b00}.
  - FIFO is flushed, including any pop/push this cycle; out_valid=0 next cycle.
  - drop_cnt <= outstanding minus the response arriving this cycle, if any. The response in the redirect cycle itself is discarded.
  - No request is issued in the redirect cycle.
  - Back-to-back redirects: each one recomputes drop_cnt from the current outstanding count.
- Pointer and count arithmetic:
  - FIFO read/write pointers wrap modulo DEPTH.
  - Counts are $clog2(DEPTH+1) bits wide.
  - PC increment wraps modulo 2^XLEN.

Decomposition:
- Shared package riscv_pkg: XLEN, ILEN=32, RESET_PC default, NOP encoding 32'h0000_0013, fetch_entry_t {pc, instr}.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO with flush, push, pop, count, and head outputs, using the same clk/rst_n.
- The top level holds the PC, counters, drop logic, and credit.

Test Plan:
- Reset, ready=1, memory latency 1, out_ready=1 -> requests at 0x0,0x4,0x8; outputs (0x0,I0),(0x4,I1) in order; out_valid first rises 2 cycles after the first request accept.
- out_ready=0 held -> after 2 requests imem_req_valid=0 and stays 0. Release out_ready -> fetch resumes at 0x8 with no lost or duplicated instructions.
- Redirect to 0x103 with 2 requests outstanding -> the next request address is 0x100. Both stale responses are dropped; the first output is (0x100, Inew).
- Redirect in the same cycle as a response and a pop -> FIFO is empty next cycle, the arriving response is discarded, drop_cnt = outstanding-1.
- imem_req_ready toggled randomly with latency 1-3 cycles, 1000 instructions -> out_pc strictly sequential by +4, and out_instr matches the memory model.
- Assert rst_n low mid-stream with the FIFO full -> out_valid=0 and imem_req_valid=0 immediately (asynchronous). After release the first request address is RESET_PC.
